slave_cmd_processor: RTL and testbench

- Parametrised command processor behind the I2C slave receiver. Collects a 3-word frame (opcode, operand A, operand B), each word marked by a done pulse from the slave.
- Synchronises done into the clk domain, then executes an ALU operation and presents a full-width result, an ASCII mnemonic for the OLED driver, and an error code through a valid/ready handshake.
- Adds a frame timeout and overrun detection.

---
 rtl/slave_cmd_processor.sv | 158 +++++++++++++++
 tb/tb_slave_cmd_processor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_cmd_processor.sv
// Three-word command frame collector and ALU behind the I2C slave receiver.
// The result and error code are held under a valid/ready handshake. Partial frames time out, and late words flag an overrun.
module slave_cmd_processor #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output logic [31:0]       opcode_ascii,
  output logic [1:0]        err_code,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [1:0]        word_cnt,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPA  = 3'd1,
    OPB  = 3'd2,
    EXEC = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state, state_nxt;
  logic                s1, s2, s3;
  logic                rx_edge;
  logic                tmo_hit;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [2:0]          opcode;
  logic [DATA_W-1:0]   op_a, op_b;

  logic [DATA_W:0]     sum, diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   alu_lo, alu_hi;
  logic [31:0]         alu_asc;
  logic [1:0]          alu_err;

  // rx_done comes from the slave clock domain; s3 turns a held level into one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_done;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_edge   = s2 & ~s3;
  assign tmo_hit   = ((state == OPA) || (state == OPB)) && !rx_edge && (tmo_cnt == CNT_MAX);
  assign state_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_edge) state_nxt = OPA;
      OPA:     if (rx_edge) state_nxt = OPB;  else if (tmo_hit) state_nxt = IDLE;
      OPB:     if (rx_edge) state_nxt = EXEC; else if (tmo_hit) state_nxt = IDLE;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_asc = "ERR ";
    alu_err = 2'd0;
    case (opcode)
      3'd0: begin alu_lo = sum[DATA_W-1:0];  alu_hi = {{(DATA_W-1){1'b0}}, sum[DATA_W]};  alu_asc = "ADD "; end
      3'd1: begin alu_lo = diff[DATA_W-1:0]; alu_hi = {{(DATA_W-1){1'b0}}, diff[DATA_W]}; alu_asc = "SUB "; end
      3'd2: begin alu_lo = prod[DATA_W-1:0]; alu_hi = prod[2*DATA_W-1:DATA_W];            alu_asc = "MUL "; end
      3'd3: begin alu_lo = op_a & op_b; alu_asc = "AND "; end
      3'd4: begin alu_lo = op_a | op_b; alu_asc = "OR  "; end
      3'd5: begin alu_lo = op_a ^ op_b; alu_asc = "XOR "; end
      3'd6: begin alu_lo = op_a; alu_hi = op_b; alu_asc = "PASS"; end
      default: alu_err = 2'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt      <= '0;
      opcode       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result_lo    <= '0;
      result_hi    <= '0;
      opcode_ascii <= '0;
      err_code     <= 2'd0;
      result_valid <= 1'b0;
      word_cnt     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (rx_edge) begin
            opcode   <= rx_data[2:0];
            err_code <= 2'd0;
            word_cnt <= 2'd1;
          end
        end
        OPA, OPB: begin
          if (rx_edge) begin
            tmo_cnt <= '0;
            if (state == OPA) begin
              op_a     <= rx_data;
              word_cnt <= 2'd2;
            end else begin
              op_b     <= rx_data;
            end
          end else if (tmo_hit) begin
            tmo_cnt  <= '0;
            err_code <= 2'd2;
            word_cnt <= 2'd0;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
        end
        EXEC: begin
          result_lo    <= alu_lo;
          result_hi    <= alu_hi;
          opcode_ascii <= alu_asc;
          err_code     <= rx_edge ? 2'd3 : alu_err;
          result_valid <= 1'b1;
          word_cnt     <= 2'd0;
        end
        HOLD: begin
          // A word arriving while a result is pending is dropped and reported
          if (rx_edge)      err_code     <= 2'd3;
          if (result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_cmd_processor.sv
// Scenario bench for slave_cmd_processor: scoreboard of expected results checked on each accepted result.
module tb_slave_cmd_processor;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [DW-1:0] result_lo, result_hi;
  logic [31:0]   opcode_ascii;
  logic [1:0]    err_code;
  logic          result_valid;
  logic          result_ready = 1'b1;
  logic [1:0]    word_cnt;
  logic [2:0]    state_out;

  typedef struct {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [31:0]   asc;
    logic [1:0]    err;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  slave_cmd_processor #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .result_lo(result_lo), .result_hi(result_hi), .opcode_ascii(opcode_ascii),
    .err_code(err_code), .result_valid(result_valid), .result_ready(result_ready),
    .word_cnt(word_cnt), .state_out(state_out)
  );

  // Scoreboard: every accepted result must match the oldest pushed expectation
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result lo=%h hi=%h err=%0d (none expected)", result_lo, result_hi, err_code);
      end else begin
        m_e = sb.pop_front();
        if ({result_lo, result_hi, opcode_ascii, err_code} !== {m_e.lo, m_e.hi, m_e.asc, m_e.err}) begin
          bad++;
          $display("FAIL result got lo=%h hi=%h asc=%h err=%0d want lo=%h hi=%h asc=%h err=%0d",
                   result_lo, result_hi, opcode_ascii, err_code, m_e.lo, m_e.hi, m_e.asc, m_e.err);
        end
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                          input logic [31:0] asc, input logic [1:0] err);
    exp_t e;
    e.lo = lo; e.hi = hi; e.asc = asc; e.err = err;
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    @(negedge clk);
    rx_data = w;
    rx_done = 1'b1;
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    send_word(op);
    send_word(a);
    send_word(b);
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({result_lo, result_hi, opcode_ascii, err_code, result_valid, word_cnt, state_out} !== '0) begin
      bad++;
      $display("FAIL reset_state got lo=%h hi=%h asc=%h err=%0d v=%b wc=%0d st=%0d want all 0",
               result_lo, result_hi, opcode_ascii, err_code, result_valid, word_cnt, state_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add_latency;
    logic [6:1] vseen;
    logic [2:0] st3;
    vseen = '0;
    push_exp(32'h8000_0000, 32'h0, 32'h4144_4420, 2'd0);
    send_word(32'h0);
    send_word(32'h7FFF_FFFF);
    @(negedge clk);
    rx_data = 32'h1;
    rx_done = 1'b1;
    st3 = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vseen[k] = result_valid;
      if (k == 3) st3 = state_out;
    end
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (st3 !== 3'd3) begin
      bad++;
      $display("FAIL exec_after_capture got state=%0d want 3", st3);
    end
    total++;
    if (vseen !== 6'b001000) begin
      bad++;
      $display("FAIL valid_pulse got %b want 001000", vseen);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL add_result_seen got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_alu;
    push_exp(32'h0000_0001, 32'hFFFF_FFFE, "MUL ", 2'd0);
    send_frame(32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp(32'hFFFF_FFFE, 32'h1, "SUB ", 2'd0);
    send_frame(32'h1, 32'h3, 32'h5);
    // upper opcode bits ignored: 0xB selects AND
    push_exp(32'h0F00_0F00, 32'h0, "AND ", 2'd0);
    send_frame(32'hB, 32'hFF00_FF00, 32'h0FF0_0FF0);
    push_exp(32'h0000_0000, 32'h1, "ADD ", 2'd0);
    send_frame(32'h0, 32'hFFFF_FFFF, 32'h1);
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL alu_results_seen got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_illegal;
    push_exp(32'h0, 32'h0, 32'h4552_5220, 2'd1);
    send_frame(32'h7, 32'h1234, 32'h5678);
    push_exp(32'h5, 32'h0, "ADD ", 2'd0);
    send_frame(32'h0, 32'h2, 32'h3);
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL illegal_results_seen got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_timeout;
    logic v;
    v = 1'b0;
    send_word(32'h0);
    total++;
    if ({state_out, word_cnt} !== {3'd1, 2'd1}) begin
      bad++;
      $display("FAIL after_opcode got st=%0d wc=%0d want st=1 wc=1", state_out, word_cnt);
    end
    send_word(32'h1);
    total++;
    if ({state_out, word_cnt} !== {3'd2, 2'd2}) begin
      bad++;
      $display("FAIL after_opa got st=%0d wc=%0d want st=2 wc=2", state_out, word_cnt);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      v |= result_valid;
    end
    total++;
    if ({state_out, err_code, word_cnt, v} !== {3'd0, 2'd2, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL timeout got st=%0d err=%0d wc=%0d valid_seen=%b want st=0 err=2 wc=0 valid_seen=0",
               state_out, err_code, word_cnt, v);
    end
    push_exp(32'h2, 32'h0, "ADD ", 2'd0);
    send_frame(32'h0, 32'h1, 32'h1);
  endtask

  task automatic test_overrun;
    @(negedge clk);
    result_ready = 1'b0;
    push_exp(32'h0000_FF00, 32'h0, "XOR ", 2'd3);
    send_frame(32'h5, 32'h0000_F0F0, 32'h0000_0FF0);
    total++;
    if ({result_valid, err_code, result_lo, state_out} !== {1'b1, 2'd0, 32'h0000_FF00, 3'd4}) begin
      bad++;
      $display("FAIL hold_result got v=%b err=%0d lo=%h st=%0d want v=1 err=0 lo=0000ff00 st=4",
               result_valid, err_code, result_lo, state_out);
    end
    send_word(32'h55);
    total++;
    if ({result_valid, err_code, result_lo, state_out} !== {1'b1, 2'd3, 32'h0000_FF00, 3'd4}) begin
      bad++;
      $display("FAIL overrun got v=%b err=%0d lo=%h st=%0d want v=1 err=3 lo=0000ff00 st=4",
               result_valid, err_code, result_lo, state_out);
    end
    @(posedge clk);
    #1 result_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({result_valid, state_out, word_cnt} !== {1'b0, 3'd0, 2'd0} || sb.size() != 0) begin
      bad++;
      $display("FAIL overrun_release got v=%b st=%0d wc=%0d pending=%0d want v=0 st=0 wc=0 pending=0",
               result_valid, state_out, word_cnt, sb.size());
    end
  endtask

  task automatic test_async_reset;
    send_word(32'h4);
    send_word(32'h0F0);
    total++;
    if (state_out !== 3'd2) begin
      bad++;
      $display("FAIL pre_reset_state got %0d want 2", state_out);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({result_lo, result_hi, opcode_ascii, err_code, result_valid, word_cnt, state_out} !== '0) begin
      bad++;
      $display("FAIL async_reset got lo=%h asc=%h err=%0d v=%b wc=%0d st=%0d want all 0",
               result_lo, opcode_ascii, err_code, result_valid, word_cnt, state_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'h0000_0FF0, 32'h0, "OR  ", 2'd0);
    send_frame(32'h4, 32'h0000_00F0, 32'h0000_0F00);
  endtask

  task automatic test_held_done;
    @(negedge clk);
    rx_data = 32'h6;
    rx_done = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if ({state_out, word_cnt} !== {3'd1, 2'd1}) begin
      bad++;
      $display("FAIL held_single_capture got st=%0d wc=%0d want st=1 wc=1", state_out, word_cnt);
    end
    repeat (38) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({state_out, err_code} !== {3'd0, 2'd2}) begin
      bad++;
      $display("FAIL held_then_timeout got st=%0d err=%0d want st=0 err=2", state_out, err_code);
    end
    push_exp(32'h0000_1234, 32'h0000_ABCD, "PASS", 2'd0);
    send_frame(32'h6, 32'h0000_1234, 32'h0000_ABCD);
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_alu();
    test_illegal();
    test_timeout();
    test_overrun();
    test_async_reset();
    test_held_done();
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_results got pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
